// File: rtl/note_lane_scheduler.sv
// Falling-note playfield sequencer: walks the song table, allocates
// per-lane note slots, advances them per tick and retires at the bottom.
module note_lane_scheduler #(
  parameter int SLOTS      = 5,
  parameter int NOTE_COUNT = 23,
  parameter int GAP_W      = 6,
  parameter int POS_W      = 10,
  parameter int BOTTOM     = 490
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     pause,
  output logic [4:0]               note_addr,
  input  logic [2:0]               note_data,
  output logic [3*SLOTS-1:0]       slot_active,
  output logic [3*SLOTS*POS_W-1:0] slot_pos,
  output logic [1:0]               state,
  output logic                     song_done,
  output logic [7:0]               drop_count
);

  localparam int N = 3 * SLOTS;
  localparam logic [POS_W-1:0] BOT = POS_W'(BOTTOM);
  localparam logic [4:0] LAST = 5'(NOTE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t st, st_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic [4:0] addr_n;
  logic [N-1:0] act_n;
  logic [N-1:0][POS_W-1:0] pos, pos_n;
  logic [7:0] drop_n;
  logic [8:0] drop_sum;
  logic [1:0] miss;
  logic found;

  assign slot_pos = pos;
  assign state = st;

  always_comb begin
    st_n = st;
    gap_n = gap;
    addr_n = note_addr;
    act_n = slot_active;
    pos_n = pos;
    drop_n = drop_count;
    drop_sum = '0;
    miss = '0;
    found = 1'b0;
    if (abort) begin
      if (st != IDLE) begin
        st_n = IDLE;
        act_n = '0;
        pos_n = '0;
      end
    end else if (!pause) begin
      unique case (st)
        IDLE: begin
          if (start) begin
            st_n = PLAY;
            addr_n = '0;
            gap_n = '0;
            drop_n = '0;
            act_n = '0;
            pos_n = '0;
          end
        end
        PLAY, DRAIN: begin
          if (tick) begin
            for (int i = 0; i < N; i++) begin
              if (slot_active[i]) begin
                if (pos[i] >= BOT) begin
                  act_n[i] = 1'b0;
                  pos_n[i] = '0;
                end else begin
                  pos_n[i] = pos[i] + 1'b1;
                end
              end
            end
            gap_n = gap + 1'b1;
            if (st == PLAY && gap == '0) begin
              // allocation looks at pre-tick occupancy only
              for (int l = 0; l < 3; l++) begin
                if (note_data[2-l]) begin
                  found = 1'b0;
                  for (int k = 0; k < SLOTS; k++) begin
                    if (!found && !slot_active[l*SLOTS+k]) begin
                      found = 1'b1;
                      act_n[l*SLOTS+k] = 1'b1;
                      pos_n[l*SLOTS+k] = '0;
                    end
                  end
                  if (!found) miss = miss + 1'b1;
                end
              end
              drop_sum = {1'b0, drop_count} + 9'(miss);
              drop_n = drop_sum[8] ? 8'hff : drop_sum[7:0];
              if (note_addr == LAST) st_n = DRAIN;
              else addr_n = note_addr + 1'b1;
            end
          end
          if (st == DRAIN && act_n == '0) st_n = DONE;
        end
        DONE: begin
          if (!start) st_n = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      gap <= '0;
      note_addr <= '0;
      slot_active <= '0;
      pos <= '0;
      drop_count <= '0;
      song_done <= 1'b0;
    end else begin
      st <= st_n;
      gap <= gap_n;
      note_addr <= addr_n;
      slot_active <= act_n;
      pos <= pos_n;
      drop_count <= drop_n;
      song_done <= (st_n == DONE);
    end
  end

endmodule

// File: doc/note_lane_scheduler.md
Name: note_lane_scheduler

Overview:
- Sequences the falling-note playfield: steps through the song note table, allocates one of SLOTS note slots per lane (red, green, blue) for each spawned note, advances slot positions on a frame tick, and retires notes at the bottom of the screen.
- Sits between the clock divider's tick strobe and the VGA pixel compare logic. It replaces ad-hoc flag and position bookkeeping with deterministic slot allocation, and adds overflow accounting and end-of-song detection.

Parameters:
- SLOTS, 5, note slots per lane; there are 3 lanes, so 3*SLOTS slots in total.
- NOTE_COUNT, 23, number of entries in the song table.
- GAP_W, 6, width of the spawn-interval counter; one note row is issued every 2^GAP_W ticks.
- POS_W, 10, width of each slot position.
- BOTTOM, 490, retirement threshold.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle advance strobe, roughly one per frame step.
- start  in  1  level; start the song from IDLE.
- abort  in  1  level; return to IDLE and clear the field.
- pause  in  1  level; freeze all state.
- note_addr  out  5  song table index.
- note_data  in  3  song table word: bit2 = red, bit1 = green, bit0 = blue. Combinational, valid in the same cycle as note_addr.
- slot_active  out  3*SLOTS  per-slot occupied flag. Lane L slot k is at index L*SLOTS+k; lane 0 = red, lane 1 = green, lane 2 = blue.
- slot_pos  out  3*SLOTS*POS_W  flattened slot positions, same slot ordering.
- state  out  2  00 IDLE, 01 PLAY, 10 DRAIN, 11 DONE.
- song_done  out  1  high while in DONE.
- drop_count  out  8  notes lost because their lane had no free slot; saturates at 255.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, all slot_active = 0, all slot_pos = 0, note_addr = 0, gap counter = 0, drop_count = 0, song_done = 0.
- Priority on each clk: abort > pause > tick.

IDLE
- start = 1 → PLAY on the next clk. At the same time: note_addr = 0, gap counter = 0, drop_count = 0, all slots cleared.

PLAY and DRAIN (only on a clk with tick = 1 and pause = 0)
- Advance: every active slot with pos < BOTTOM gets pos + 1.
- Retire: every active slot with pos >= BOTTOM gets active = 0 and pos = 0 on the same tick.
- The gap counter increments modulo 2^GAP_W.
- Spawn happens in PLAY only, and only when the gap counter equals 0 before the increment. For each lane whose note_data bit is 1:
  - Allocate the lowest-index slot in that lane that was inactive before this tick. A slot retiring on this tick is not reusable until the next tick.
  - The new slot gets active = 1, pos = 0.
  - If no slot is free, drop_count += 1 for that lane (up to +3 per row), saturating at 255.
  - After the row is handled: note_addr += 1. If the row just issued was NOTE_COUNT-1, go to DRAIN instead, and note_addr holds at NOTE_COUNT-1.
- An all-zero row consumes a spawn interval but allocates nothing.
- DRAIN → DONE on the first clk where all slot_active = 0 (evaluated after the tick update).

DONE
- song_done = 1, slots stay cleared. Go to IDLE when start = 0.

Interrupts
- pause = 1: tick is ignored entirely. Positions, gap counter, note_addr and state hold. abort still takes effect.
- abort = 1 in PLAY, DRAIN or DONE: IDLE on the next clk, all slots cleared. note_addr and drop_count hold until the next start.
- Reset mid-song: immediate return to reset values, with no partial spawn.

Outputs and widths
- All outputs are registered.
- Positions never exceed BOTTOM.
- The gap counter wraps 2^GAP_W-1 → 0 with no hold.

Test Plan:
- Reset low, then release; start = 1; table row 0 = 000, row 1 = 001 → after tick 1, no slot active and note_addr = 1. After tick 65, blue slot 10 is active with pos = 0. After tick 66, it has pos = 1.
- A single red note spawned at tick T → pos = 490 at tick T+490. Slot cleared at tick T+491 with slot_active[0] = 0. No other slot is affected.
- A row of 111 presented 6 times while all slots are still in flight → slots 0-4, 5-9 and 10-14 fill in index order. The 6th row increments drop_count by 3 (to 3), and no slot changes.
- Full 23-row song with GAP_W reduced to 2 → state 01 → 10 after row 22 is issued. State 10 → 11 after the last slot retires; song_done = 1. start low → state 00.
- pause held for 100 clks with tick pulsing → slot_pos, note_addr and the gap counter are unchanged. Releasing pause resumes on the next tick with pos + 1.
- abort in PLAY with 7 slots active → state 00 and slot_active = 0 next clk. Asserting reset low mid-tick → all outputs at reset values immediately, without waiting for a clk edge.
